// File: rtl/tt_um_jleugeri_token_emitter.sv
// Token emitter: folds token_start/token_end pulses from N upstream sources into
// per-cycle signed good/bad token deltas. Totals larger than one output word are
// parked in saturating pending accumulators and drained one max-magnitude delta per cycle.
module tt_um_jleugeri_token_emitter #(
    parameter int N_SOURCES = 4,
    parameter int W_BITS    = 4,
    parameter int OUT_BITS  = 4,
    parameter int ACC_BITS  = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [N_SOURCES-1:0]          src_token_start,
    input  logic [N_SOURCES-1:0]          src_token_end,
    input  logic [N_SOURCES*W_BITS-1:0]   good_weights,
    input  logic [N_SOURCES*W_BITS-1:0]   bad_weights,
    input  logic                          clear,
    output logic [OUT_BITS-1:0]           new_good_tokens,
    output logic [OUT_BITS-1:0]           new_bad_tokens,
    output logic [N_SOURCES-1:0]          active,
    output logic                          busy,
    output logic                          overflow,
    output logic                          protocol_error
);

    // Wide enough for pending + every source contributing at once without wrapping.
    localparam int SUM_W     = ACC_BITS + W_BITS + $clog2(N_SOURCES) + 1;
    localparam int ACC_MAX_I = (1 << (ACC_BITS - 1)) - 1;
    localparam int ACC_MIN_I = -(1 << (ACC_BITS - 1));
    localparam int OUT_MAX_I = (1 << (OUT_BITS - 1)) - 1;
    localparam int OUT_MIN_I = -(1 << (OUT_BITS - 1));

    localparam logic signed [SUM_W-1:0]    SUM_HI = SUM_W'(ACC_MAX_I);
    localparam logic signed [SUM_W-1:0]    SUM_LO = SUM_W'(ACC_MIN_I);
    localparam logic signed [ACC_BITS-1:0] ACC_HI = ACC_BITS'(ACC_MAX_I);
    localparam logic signed [ACC_BITS-1:0] ACC_LO = ACC_BITS'(ACC_MIN_I);
    localparam logic signed [ACC_BITS-1:0] OUT_HI_A = ACC_BITS'(OUT_MAX_I);
    localparam logic signed [ACC_BITS-1:0] OUT_LO_A = ACC_BITS'(OUT_MIN_I);
    localparam logic signed [OUT_BITS-1:0] OUT_HI = OUT_BITS'(OUT_MAX_I);
    localparam logic signed [OUT_BITS-1:0] OUT_LO = OUT_BITS'(OUT_MIN_I);

    function automatic logic signed [SUM_W-1:0] sext_w(input logic [W_BITS-1:0] w);
        return {{(SUM_W - W_BITS){w[W_BITS-1]}}, w};
    endfunction

    function automatic logic signed [SUM_W-1:0] sext_acc(input logic [ACC_BITS-1:0] a);
        return {{(SUM_W - ACC_BITS){a[ACC_BITS-1]}}, a};
    endfunction

    function automatic logic signed [ACC_BITS-1:0] sext_out(input logic [OUT_BITS-1:0] o);
        return {{(ACC_BITS - OUT_BITS){o[OUT_BITS-1]}}, o};
    endfunction

    function automatic logic acc_clips(input logic signed [SUM_W-1:0] v);
        return (v > SUM_HI) || (v < SUM_LO);
    endfunction

    function automatic logic signed [ACC_BITS-1:0] sat_acc(input logic signed [SUM_W-1:0] v);
        if (v > SUM_HI) return ACC_HI;
        else if (v < SUM_LO) return ACC_LO;
        else return v[ACC_BITS-1:0];
    endfunction

    function automatic logic signed [OUT_BITS-1:0] clamp_out(input logic signed [ACC_BITS-1:0] t);
        if (t > OUT_HI_A) return OUT_HI;
        else if (t < OUT_LO_A) return OUT_LO;
        else return t[OUT_BITS-1:0];
    endfunction

    logic signed [ACC_BITS-1:0] pg_q, pg_d, pb_q, pb_d;
    logic signed [OUT_BITS-1:0] good_q, good_d, bad_q, bad_d;
    logic [N_SOURCES-1:0]       act_q, act_d;
    logic                       ovf_q, ovf_d, perr_q, perr_d;

    logic signed [SUM_W-1:0]    dg, db, sum_g, sum_b;
    logic signed [ACC_BITS-1:0] tg, tb;

    // Classify each source's pulses, sum legal contributions, saturate and split into output + residue.
    always_comb begin
        dg     = '0;
        db     = '0;
        act_d  = act_q;
        perr_d = perr_q;
        for (int i = 0; i < N_SOURCES; i++) begin
            if (src_token_start[i] && src_token_end[i]) begin
                perr_d = 1'b1;
            end else if (src_token_start[i]) begin
                if (act_q[i]) begin
                    perr_d = 1'b1;
                end else begin
                    dg       = dg + sext_w(good_weights[i*W_BITS +: W_BITS]);
                    db       = db + sext_w(bad_weights[i*W_BITS +: W_BITS]);
                    act_d[i] = 1'b1;
                end
            end else if (src_token_end[i]) begin
                if (!act_q[i]) begin
                    perr_d = 1'b1;
                end else begin
                    dg       = dg - sext_w(good_weights[i*W_BITS +: W_BITS]);
                    db       = db - sext_w(bad_weights[i*W_BITS +: W_BITS]);
                    act_d[i] = 1'b0;
                end
            end
        end

        sum_g  = sext_acc(pg_q) + dg;
        sum_b  = sext_acc(pb_q) + db;
        tg     = sat_acc(sum_g);
        tb     = sat_acc(sum_b);
        ovf_d  = ovf_q | acc_clips(sum_g) | acc_clips(sum_b);
        good_d = clamp_out(tg);
        bad_d  = clamp_out(tb);
        // Residue keeps the sign of T and shrinks toward zero, so draining is monotone.
        pg_d   = tg - sext_out(good_d);
        pb_d   = tb - sext_out(bad_d);

        if (clear) begin
            act_d  = '0;
            perr_d = 1'b0;
            ovf_d  = 1'b0;
            good_d = '0;
            bad_d  = '0;
            pg_d   = '0;
            pb_d   = '0;
        end
    end

    // State and registered outputs; async reset dominates clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pg_q   <= '0;
            pb_q   <= '0;
            good_q <= '0;
            bad_q  <= '0;
            act_q  <= '0;
            ovf_q  <= 1'b0;
            perr_q <= 1'b0;
        end else begin
            pg_q   <= pg_d;
            pb_q   <= pb_d;
            good_q <= good_d;
            bad_q  <= bad_d;
            act_q  <= act_d;
            ovf_q  <= ovf_d;
            perr_q <= perr_d;
        end
    end

    assign new_good_tokens = good_q;
    assign new_bad_tokens  = bad_q;
    assign active          = act_q;
    assign busy            = (pg_q != '0) || (pb_q != '0);
    assign overflow        = ovf_q;
    assign protocol_error  = perr_q;

endmodule

// File: tb/tb_tt_um_jleugeri_token_emitter.sv
// Bench for the token emitter: directed scenarios followed by randomized pulses,
// all compared against an integer reference model of the token accounting rules.
module tb_tt_um_jleugeri_token_emitter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  st, en;
    logic [15:0] good_weights, bad_weights;
    logic        clear;
    logic [3:0]  new_good_tokens, new_bad_tokens, active;
    logic        busy, overflow, protocol_error;

    logic signed [3:0] gw [4];
    logic signed [3:0] bw [4];

    int checks   = 0;
    int failures = 0;

    // reference model state
    int m_pg, m_pb, m_og, m_ob, m_ovf, m_perr;
    bit [3:0] m_act;

    tt_um_jleugeri_token_emitter dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .src_token_start (st),
        .src_token_end   (en),
        .good_weights    (good_weights),
        .bad_weights     (bad_weights),
        .clear           (clear),
        .new_good_tokens (new_good_tokens),
        .new_bad_tokens  (new_bad_tokens),
        .active          (active),
        .busy            (busy),
        .overflow        (overflow),
        .protocol_error  (protocol_error)
    );

    // pack per-source weights onto the buses
    always_comb begin
        good_weights = '0;
        bad_weights  = '0;
        for (int i = 0; i < 4; i++) begin
            good_weights[i*4 +: 4] = gw[i];
            bad_weights[i*4 +: 4]  = bw[i];
        end
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pg = 0; m_pb = 0; m_og = 0; m_ob = 0; m_ovf = 0; m_perr = 0; m_act = '0;
    endtask

    // accumulate, saturate to [-128,127], emit at most [-8,7], keep the rest pending
    task automatic model_path(inout int p, input int d, output int o);
        int t;
        t = p + d;
        if (t > 127) begin t = 127; m_ovf = 1; end
        if (t < -128) begin t = -128; m_ovf = 1; end
        o = (t > 7) ? 7 : ((t < -8) ? -8 : t);
        p = t - o;
    endtask

    task automatic model_step();
        int dg, db;
        if (clear) begin
            model_reset();
            return;
        end
        dg = 0; db = 0;
        for (int i = 0; i < 4; i++) begin
            if (st[i] && en[i]) m_perr = 1;
            else if (st[i] && m_act[i]) m_perr = 1;
            else if (st[i]) begin
                dg += int'(gw[i]); db += int'(bw[i]); m_act[i] = 1'b1;
            end
            else if (en[i] && !m_act[i]) m_perr = 1;
            else if (en[i]) begin
                dg -= int'(gw[i]); db -= int'(bw[i]); m_act[i] = 1'b0;
            end
        end
        model_path(m_pg, dg, m_og);
        model_path(m_pb, db, m_ob);
    endtask

    task automatic check_all(input string tag);
        check({tag, "_good"}, $signed(new_good_tokens), m_og);
        check({tag, "_bad"},  $signed(new_bad_tokens),  m_ob);
        check({tag, "_active"}, {28'd0, active}, {28'd0, m_act});
        check({tag, "_busy"}, {31'd0, busy}, ((m_pg != 0) || (m_pb != 0)) ? 1 : 0);
        check({tag, "_ovf"},  {31'd0, overflow}, m_ovf);
        check({tag, "_perr"}, {31'd0, protocol_error}, m_perr);
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    // reset asserted between edges; outputs must drop without a clock
    task automatic async_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #1 rst_n = 1'b1;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick("clr");
        clear = 1'b0;
    endtask

    task automatic set_all_weights(input logic signed [3:0] g, input logic signed [3:0] b);
        for (int i = 0; i < 4; i++) begin gw[i] = g; bw[i] = b; end
    endtask

    int exp3 [5] = '{5, 0, 0, -5, 0};
    int exp2b [5] = '{1, 1, 1, 0, 0};

    initial begin
        rst_n = 1'b0; st = '0; en = '0; clear = 1'b0;
        set_all_weights(4'sd0, 4'sd0);
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        check_all("reset");
        rst_n = 1'b1;

        // single start: good=+3, bad=-2 for one cycle
        gw[0] = 4'sd3; bw[0] = -4'sd2;
        for (int k = 0; k < 4; k++) tick("t1_idle");
        st = 4'b0001;
        tick("t1_start");
        st = '0;
        check("t1_good_const", $signed(new_good_tokens), 3);
        check("t1_bad_const",  $signed(new_bad_tokens), -2);
        check("t1_active_const", {28'd0, active}, 1);
        tick("t1_after");
        check("t1_good_zero", $signed(new_good_tokens), 0);
        do_clear();

        // four simultaneous +7 starts drain as 7,7,7,7,0
        set_all_weights(4'sd7, 4'sd0);
        st = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            tick("t2");
            st = '0;
            check("t2_good_const", $signed(new_good_tokens), (k < 4) ? 7 : 0);
            check("t2_busy_const", {31'd0, busy}, exp2b[k]);
        end
        do_clear();

        // start then end three cycles later: +5,0,0,-5,0
        gw[0] = 4'sd5; bw[0] = 4'sd0;
        for (int k = 0; k < 5; k++) begin
            st = (k == 0) ? 4'b0001 : 4'b0000;
            en = (k == 3) ? 4'b0001 : 4'b0000;
            tick("t3");
            check("t3_good_const", $signed(new_good_tokens), exp3[k]);
            check("t3_act0_const", {31'd0, active[0]}, (k < 3) ? 1 : 0);
        end
        st = '0; en = '0;

        // orphan end is ignored but flagged until clear
        en = 4'b0010;
        tick("t4");
        en = '0;
        check("t4_perr_const", {31'd0, protocol_error}, 1);
        check("t4_good_const", $signed(new_good_tokens), 0);
        tick("t4_hold");
        do_clear();
        check("t4_perr_cleared", {31'd0, protocol_error}, 0);

        // +28 every cycle: start at +7, end with weights flipped to -7
        for (int k = 0; k < 8; k++) begin
            set_all_weights(4'sd7, 4'sd0);
            st = 4'b1111;
            tick("t5_up");
            st = '0;
            set_all_weights(-4'sd7, 4'sd0);
            en = 4'b1111;
            tick("t5_up");
            en = '0;
        end
        check("t5_ovf_const", {31'd0, overflow}, 1);
        for (int k = 0; k < 40 && (m_pg != 0 || m_pb != 0); k++) tick("t5_drain");
        check("t5_busy_done", {31'd0, busy}, 0);
        tick("t5_idle");
        check("t5_good_done", $signed(new_good_tokens), 0);
        do_clear();

        // async reset while PG=14
        set_all_weights(4'sd7, 4'sd0);
        st = 4'b1111;
        tick("t6");
        st = '0;
        tick("t6");
        check("t6_busy_before", {31'd0, busy}, 1);
        async_reset("t6_arst");
        check("t6_good_const", $signed(new_good_tokens), 0);
        check("t6_busy_const", {31'd0, busy}, 0);
        tick("t6_idle");
        tick("t6_idle");

        // randomized pulses, weights, clears and resets
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(7) == 0) begin
                for (int i = 0; i < 4; i++) begin
                    gw[i] = 4'($urandom);
                    bw[i] = 4'($urandom);
                end
            end
            for (int i = 0; i < 4; i++) begin
                st[i] = ($urandom_range(3) == 0);
                en[i] = ($urandom_range(3) == 0);
            end
            clear = ($urandom_range(39) == 0);
            tick("rnd");
            if ($urandom_range(99) == 0) async_reset("rnd_arst");
        end
        st = '0; en = '0; clear = 1'b0;
        for (int k = 0; k < 3; k++) tick("end");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
